i2s_clk_cfg_ctrl: RTL and testbench
===================================

Name: i2s_clk_cfg_ctrl

Overview:
Run/configuration sequencer for the I2S clock divider (bclk/lrck generator) in the mclki domain. Accepts start/stop requests and new bclk_factor/word_width settings over a valid/ready handshake. Drives the divider's enable and configuration inputs. Applies changes only at an lrck frame boundary, followed by a settle gap, so the divider never emits a truncated frame or a mixed-configuration frame.

Parameters:
DEF_BCLK_FACTOR, 5'd4, bclk_factor value driven after reset
DEF_WORD_WIDTH, 6'd32, word_width value driven after reset; must be 16 or 32
SETTLE_CYCLES, 4, mclki cycles enable is held low after a config apply before re-enable; legal range 2..15
TIMEOUT_CYCLES, 4096, drain timeout in mclki cycles (used only with the optional feature)

Ports:
mclki  input  1  clock, 24.576 MHz x4
rst_n  input  1  asynchronous, active-low reset
run_req  input  1  level; 1 = divider should run
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  controller can accept configuration
cfg_bclk_factor  input  5  requested bclk divide factor
cfg_word_width  input  6  requested word width, 16 or 32
cfg_err  output  1  1-cycle pulse: offered config rejected
cfg_done  output  1  1-cycle pulse: accepted config is now driving the divider
div_lrck  input  1  lrck returned from the divider; synchronous to mclki
div_enable  output  1  divider enable
div_bclk_factor  output  5  divider bclk_factor
div_word_width  output  6  divider word_width
busy  output  1  state is SETTLE or DRAIN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = OFF, div_enable = 0.
  - div_bclk_factor = DEF_BCLK_FACTOR, div_word_width = DEF_WORD_WIDTH.
  - cfg_err = 0, cfg_done = 0, pending registers cleared.
  - Reset deassertion takes effect on the next mclki edge.
- Config validity: bclk_factor != 0 AND word_width in {16, 32}.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - Invalid config: accepted (consumed), cfg_err pulses on the next cycle, no other effect.
- cfg_ready = 1 in OFF and RUN; 0 in SETTLE and DRAIN.
- Frame boundary = falling edge of div_lrck, detected with a registered copy (lrck_q && !div_lrck).
- States:
  - OFF: div_enable = 0.
    - Valid config: written directly to div_* outputs; cfg_done pulses the next cycle.
    - run_req = 1: go to SETTLE.
    - Config and run_req in the same cycle: config applied first, then SETTLE.
  - SETTLE: div_enable = 0; counter runs SETTLE_CYCLES cycles.
    - Then: RUN if run_req = 1, else OFF.
    - run_req dropping during SETTLE returns to OFF at the end of the count.
  - RUN: div_enable = 1.
    - Valid config: latched into pending (pend_valid = 1), go to DRAIN with restart = 1.
    - run_req = 0: go to DRAIN with restart = 0.
    - Both in the same cycle: config latched and restart = 0 (stop wins).
  - DRAIN: div_enable stays 1 until the frame boundary. On that cycle:
    - div_enable goes 0 on the next edge.
    - If pend_valid: pending copied to div_*, cfg_done pulses, pend_valid cleared.
    - Next state = SETTLE if restart && run_req, else OFF.
    - run_req falling during DRAIN clears restart.
- Latency:
  - OFF config apply: div_* update 1 cycle after the transfer.
  - RUN config apply: div_* update at the first lrck falling edge after the transfer; div_enable returns to 1 SETTLE_CYCLES+1 cycles later.
- div_* outputs never change while div_enable = 1.

Optional Feature:
Macro I2S_CFG_CTRL_TIMEOUT_EN.
- Defined: DRAIN counts mclki cycles. On reaching TIMEOUT_CYCLES without a boundary (divider stalled or lrck stuck):
  - force the same actions as a boundary (disable, apply pending, cfg_done);
  - additionally pulse cfg_err with the apply.
  - Counter clears on DRAIN entry.
- Not defined: DRAIN waits indefinitely; no counter logic is present.

Test Plan:
- Reset → div_enable = 0, div_bclk_factor = 4, div_word_width = 32, cfg_ready = 1.
- In OFF, send cfg (8, 16) → div_* = (8, 16) next cycle, cfg_done 1 pulse. Then run_req = 1 → div_enable rises after exactly 4 cycles.
- In RUN with factor 4/width 32, send cfg (2, 16) mid-frame → div_enable stays 1 until the lrck fall. Next edge: div_enable = 0, div_* = (2, 16), cfg_done pulse. div_enable = 1 again 4 cycles later. No lrck period other than 512 or 128 mclki cycles is observed.
- Send cfg (0, 32) and cfg (4, 24) → each gives a cfg_err pulse, div_* unchanged, state unchanged.
- In RUN, drop run_req and send cfg (6, 32) in the same cycle → at the boundary, div_* = (6, 32) and state goes to OFF (no re-enable).
- Assert rst_n low during DRAIN → outputs return to reset values immediately (asynchronous); pending config discarded. With I2S_CFG_CTRL_TIMEOUT_EN defined, hold div_lrck at 0 in DRAIN → forced apply plus cfg_err after 4096 cycles.

Source files
------------

// File: rtl/i2s_clk_cfg_ctrl.sv
// Run/config sequencer for the I2S bclk/lrck divider (mclki domain).
// Optional drain timeout: define I2S_CFG_CTRL_TIMEOUT_EN.
module i2s_clk_cfg_ctrl #(
  parameter logic [4:0] DEF_BCLK_FACTOR = 5'd4,
  parameter logic [5:0] DEF_WORD_WIDTH  = 6'd32,
  parameter int         SETTLE_CYCLES   = 4,
  parameter int         TIMEOUT_CYCLES  = 4096
) (
  input  logic       mclki,
  input  logic       rst_n,
  input  logic       run_req,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [4:0] cfg_bclk_factor,
  input  logic [5:0] cfg_word_width,
  output logic       cfg_err,
  output logic       cfg_done,
  input  logic       div_lrck,
  output logic       div_enable,
  output logic [4:0] div_bclk_factor,
  output logic [5:0] div_word_width,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_OFF,
    S_SETTLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [3:0] SETTLE_LAST =
    4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_d;
  logic       lrck_q;
  logic       boundary;
  logic       xfer;
  logic       cfg_ok;
  logic       fire;
  logic       tmo;
  logic [3:0] scnt;
  logic [4:0] pend_f;
  logic [5:0] pend_w;
  logic       pend_valid;
  logic       restart;
  logic       restart_d;
  logic       ld_off;
  logic       ld_pend;
  logic       apply;
  logic       err_d;
  logic       done_d;

  assign boundary = lrck_q && !div_lrck;
  assign cfg_ok   = (cfg_bclk_factor != 5'd0) &&
                    ((cfg_word_width == 6'd16) ||
                     (cfg_word_width == 6'd32));
  assign xfer     = cfg_valid && cfg_ready;
  assign fire     = boundary || tmo;

  assign cfg_ready  = (state == S_OFF) ||
                      (state == S_RUN);
  assign div_enable = (state == S_RUN) ||
                      (state == S_DRAIN);
  assign busy       = (state == S_SETTLE) ||
                      (state == S_DRAIN);

`ifdef I2S_CFG_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  assign tmo = (state == S_DRAIN) &&
               (tcnt == TMO_LAST);

  // restarts from zero on every DRAIN entry
  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if ((state == S_DRAIN) &&
                 (state_d == S_DRAIN)) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    restart_d = restart;
    ld_off    = 1'b0;
    ld_pend   = 1'b0;
    apply     = 1'b0;
    unique case (state)
      S_OFF: begin
        ld_off = xfer && cfg_ok;
        if (run_req) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt == SETTLE_LAST)
          state_d = run_req ? S_RUN : S_OFF;
      end
      S_RUN: begin
        ld_pend = xfer && cfg_ok;
        // stop wins over a restart request
        if (ld_pend || !run_req) begin
          state_d   = S_DRAIN;
          restart_d = run_req;
        end
      end
      S_DRAIN: begin
        restart_d = restart && run_req;
        if (fire) begin
          apply   = pend_valid;
          state_d = (restart && run_req) ?
                    S_SETTLE : S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
    err_d  = (xfer && !cfg_ok) ||
             (tmo && !boundary);
    done_d = ld_off || apply;
  end

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OFF;
      restart <= 1'b0;
      scnt    <= '0;
    end else begin
      state   <= state_d;
      restart <= restart_d;
      if ((state == S_SETTLE) &&
          (state_d == S_SETTLE))
        scnt <= scnt + 1'b1;
      else
        scnt <= '0;
    end
  end

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      lrck_q          <= 1'b0;
      cfg_err         <= 1'b0;
      cfg_done        <= 1'b0;
      pend_valid      <= 1'b0;
      pend_f          <= '0;
      pend_w          <= '0;
      div_bclk_factor <= DEF_BCLK_FACTOR;
      div_word_width  <= DEF_WORD_WIDTH;
    end else begin
      lrck_q   <= div_lrck;
      cfg_err  <= err_d;
      cfg_done <= done_d;
      if (ld_off) begin
        div_bclk_factor <= cfg_bclk_factor;
        div_word_width  <= cfg_word_width;
      end
      if (ld_pend) begin
        pend_f     <= cfg_bclk_factor;
        pend_w     <= cfg_word_width;
        pend_valid <= 1'b1;
      end
      if (apply) begin
        div_bclk_factor <= pend_f;
        div_word_width  <= pend_w;
        pend_valid      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_clk_cfg_ctrl.sv
// Scoreboard bench for i2s_clk_cfg_ctrl with a behavioural
// bclk/lrck divider model closing the lrck loop.
module tb_i2s_clk_cfg_ctrl;

  logic       mclki = 1'b0;
  logic       rst_n = 1'b1;
  logic       run_req = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [4:0] cfg_bclk_factor = '0;
  logic [5:0] cfg_word_width = '0;
  logic       cfg_err;
  logic       cfg_done;
  logic       div_lrck;
  logic       div_enable;
  logic [4:0] div_bclk_factor;
  logic [5:0] div_word_width;
  logic       busy;

  i2s_clk_cfg_ctrl dut (
    .mclki           (mclki),
    .rst_n           (rst_n),
    .run_req         (run_req),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_bclk_factor (cfg_bclk_factor),
    .cfg_word_width  (cfg_word_width),
    .cfg_err         (cfg_err),
    .cfg_done        (cfg_done),
    .div_lrck        (div_lrck),
    .div_enable      (div_enable),
    .div_bclk_factor (div_bclk_factor),
    .div_word_width  (div_word_width),
    .busy            (busy)
  );

  always #5 mclki = ~mclki;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] kind;
    logic [4:0] f;
    logic [5:0] w;
    logic       en;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic void chk(string nm,
                              int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, req);
    end
  endfunction

  // divider model: frame = 4*factor*width mclki
  logic [11:0] dcnt = '0;
  logic [11:0] dnxt;
  logic [11:0] half;
  logic        lrck_m = 1'b0;
  logic        hold = 1'b0;

  assign half = 12'(2 * int'(div_bclk_factor) *
                    int'(div_word_width));
  assign dnxt = (dcnt == 12'(2 * int'(half) - 1)) ?
                12'd0 : dcnt + 12'd1;
  assign div_lrck = lrck_m & ~hold;

  always @(posedge mclki) begin
    if (!div_enable) begin
      dcnt   <= '0;
      lrck_m <= 1'b0;
    end else begin
      dcnt   <= dnxt;
      lrck_m <= (dnxt >= half);
    end
  end

  always @(negedge mclki) begin
    if (rst_n && (cfg_done || cfg_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pulse: got done=%0d err=%0d want none",
                 cfg_done, cfg_err);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {cfg_err, cfg_done}, e.kind);
        chk("pulse_factor", div_bclk_factor, e.f);
        chk("pulse_width", div_word_width, e.w);
        chk("pulse_enable", div_enable, e.en);
      end
    end
  end

  logic prev_l = 1'b0;
  int   per = 0;
  bit   armed = 1'b0;

  always @(negedge mclki) begin
    if (!div_enable) begin
      armed = 1'b0;
    end else if (prev_l && !div_lrck) begin
      if (armed)
        chk("lrck_period", per, (per == 128) ? 128 : 512);
      armed = 1'b1;
      per = 0;
    end
    per++;
    prev_l = div_lrck;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclki);
      #1;
    end
  endtask

  task automatic send_cfg(input logic [4:0] f,
                          input logic [5:0] w,
                          input logic run,
                          input logic [1:0] kind,
                          input logic [4:0] ef,
                          input logic [5:0] ew,
                          input logic een);
    exp_t x;
    int   k;
    for (k = 0; k < 50 && !cfg_ready; k++) step(1);
    if (!cfg_ready) chk("ready_wait", 0, 1);
    x.kind = kind;
    x.f = ef;
    x.w = ew;
    x.en = een;
    sb.push_back(x);
    cfg_valid = 1'b1;
    cfg_bclk_factor = f;
    cfg_word_width = w;
    run_req = run;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_en(input logic v,
                         input int lim,
                         input string nm);
    int k;
    for (k = 0; k < lim && div_enable != v; k++)
      step(1);
    chk(nm, div_enable, v);
  endtask

  initial begin
    int   n;
    int   ok;
    logic p;
    logic pp;

    #2 rst_n = 1'b0;
    step(3);
    chk("rst_enable", div_enable, 0);
    chk("rst_factor", div_bclk_factor, 4);
    chk("rst_width", div_word_width, 32);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    step(2);

    send_cfg(5'd8, 6'd16, 1'b0, 2'b01, 5'd8, 6'd16, 1'b0);
    chk("off_apply_f", div_bclk_factor, 8);
    chk("off_apply_w", div_word_width, 16);
    send_cfg(5'd0, 6'd32, 1'b0, 2'b10, 5'd8, 6'd16, 1'b0);
    send_cfg(5'd4, 6'd24, 1'b0, 2'b10, 5'd8, 6'd16, 1'b0);
    step(2);
    chk("bad_cfg_f", div_bclk_factor, 8);
    chk("bad_cfg_w", div_word_width, 16);
    chk("bad_cfg_busy", busy, 0);

    run_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && !div_enable; i++) begin
      step(1);
      if (busy) n++;
    end
    chk("settle_cycles", n, 4);
    chk("run_enable", div_enable, 1);
    step(1100);

    send_cfg(5'd2, 6'd16, 1'b1, 2'b01, 5'd2, 6'd16, 1'b0);
    chk("drain_ready", cfg_ready, 0);
    chk("drain_busy", busy, 1);
    chk("drain_enable", div_enable, 1);
    chk("drain_hold_f", div_bclk_factor, 8);
    p = div_lrck;
    pp = p;
    ok = 0;
    for (int i = 0; i < 1200; i++) begin
      step(1);
      if (!div_enable) begin
        ok = 1;
        break;
      end
      pp = p;
      p = div_lrck;
    end
    chk("drain_ends", ok, 1);
    chk("disable_after_fall", {pp, p}, 2);
    n = busy ? 1 : 0;
    for (int i = 0; i < 20 && !div_enable; i++) begin
      step(1);
      if (busy) n++;
    end
    chk("resettle_cycles", n, 4);
    chk("rerun_enable", div_enable, 1);
    step(400);

    send_cfg(5'd0, 6'd32, 1'b1, 2'b10, 5'd2, 6'd16, 1'b1);
    step(1);
    chk("run_bad_enable", div_enable, 1);
    chk("run_bad_busy", busy, 0);

    send_cfg(5'd6, 6'd32, 1'b0, 2'b01, 5'd6, 6'd32, 1'b0);
    wait_en(1'b0, 400, "stop_disable");
    step(20);
    chk("stop_enable", div_enable, 0);
    chk("stop_busy", busy, 0);
    chk("stop_ready", cfg_ready, 1);
    chk("stop_f", div_bclk_factor, 6);
    chk("stop_w", div_word_width, 32);

    run_req = 1'b1;
    wait_en(1'b1, 30, "run2_enable");
    step(50);
    send_cfg(5'd3, 6'd16, 1'b1, 2'b01, 5'd3, 6'd16, 1'b0);
    step(3);
    chk("drain2_busy", busy, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_enable", div_enable, 0);
    chk("arst_f", div_bclk_factor, 4);
    chk("arst_w", div_word_width, 32);
    chk("arst_busy", busy, 0);
    run_req = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1000);
    chk("post_rst_f", div_bclk_factor, 4);
    chk("post_rst_en", div_enable, 0);

`ifdef I2S_CFG_CTRL_TIMEOUT_EN
    run_req = 1'b1;
    wait_en(1'b1, 30, "run3_enable");
    step(10);
    hold = 1'b1;
    send_cfg(5'd5, 6'd16, 1'b1, 2'b11, 5'd5, 6'd16, 1'b0);
    n = 0;
    for (int i = 0; i < 5000 && div_enable; i++) begin
      step(1);
      n++;
    end
    chk("timeout_cycles", n, 4096);
    hold = 1'b0;
    run_req = 1'b0;
    step(20);
`endif

    step(20);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
